// File: rtl/mult_div_unit.sv
// mult_div_unit
// Multi-cycle multiply/divide unit for the EX stage. Owns the HI/LO
// registers, executes mult/multu/div/divu (timed by a busy counter) and
// single-cycle mthi/mtlo, and raises the ID-stage stall request.
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous, active-high reset
//   data1   in   rs operand (dividend / multiplicand / mthi, mtlo source)
//   data2   in   rt operand (divisor / multiplier)
//   MDOp    in   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   start   in   EX-stage instruction is a valid MD instruction
//   md_use  in   ID-stage instruction is MD or reads HI/LO
//   busy    out  multi-cycle operation in progress
//   stall   out  ID stall request
//   HI, LO  out  architectural HI/LO registers
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] data1,
   input  logic [31:0] data2,
   input  logic [2:0]  MDOp,
   input  logic        start,
   input  logic        md_use,
   output logic        busy,
   output logic        stall,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

   // Full-width arithmetic; each returns {hi, lo}.
   function automatic logic [63:0] mul_signed(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
      logic signed [63:0] ax;
      logic signed [63:0] bx;
      ax = 64'(a);
      bx = 64'(b);
      return ax * bx;
   endfunction

   function automatic logic [63:0] mul_unsigned(input logic [31:0] a,
                                                input logic [31:0] b);
      logic [63:0] ax;
      logic [63:0] bx;
      ax = {32'd0, a};
      bx = {32'd0, b};
      return ax * bx;
   endfunction

   // Quotient truncates toward zero, remainder takes the dividend's sign.
   // A zero divisor yields zero here; the caller suppresses the write.
   function automatic logic [63:0] div_signed(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
      logic signed [31:0] q;
      logic signed [31:0] r;
      if (b == 32'sd0) begin
         q = 32'sd0;
         r = 32'sd0;
      end else begin
         q = a / b;
         r = a % b;
      end
      return {r, q};
   endfunction

   function automatic logic [63:0] div_unsigned(input logic [31:0] a,
                                                input logic [31:0] b);
      logic [31:0] q;
      logic [31:0] r;
      if (b == 32'd0) begin
         q = 32'd0;
         r = 32'd0;
      end else begin
         q = a / b;
         r = a % b;
      end
      return {r, q};
   endfunction

   logic [3:0]  cnt;
   logic [31:0] hi_reg;
   logic [31:0] lo_reg;
   logic [31:0] pend_hi_p1;
   logic [31:0] pend_lo_p1;
   logic        pend_we_p1;

   logic        is_md_op;
   logic [63:0] res_p0;
   logic        res_we_p0;

   assign busy  = (cnt != 4'd0);
   assign HI    = hi_reg;
   assign LO    = lo_reg;
   assign is_md_op = (MDOp == OP_MULT) || (MDOp == OP_MULTU) ||
                     (MDOp == OP_DIV)  || (MDOp == OP_DIVU);
   assign stall = md_use & (busy | (start & is_md_op));

   // Launch stage: full result computed from the operands present at launch.
   always_comb begin
      res_p0    = 64'd0;
      res_we_p0 = 1'b1;
      case (MDOp)
         OP_MULT:  res_p0 = mul_signed(data1, data2);
         OP_MULTU: res_p0 = mul_unsigned(data1, data2);
         OP_DIV: begin
            res_p0    = div_signed(data1, data2);
            res_we_p0 = (data2 != 32'd0);
         end
         OP_DIVU: begin
            res_p0    = div_unsigned(data1, data2);
            res_we_p0 = (data2 != 32'd0);
         end
         default: res_we_p0 = 1'b0;
      endcase
   end

   // Pending stage: result waits here until the counter expires.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= 4'd0;
         hi_reg     <= 32'd0;
         lo_reg     <= 32'd0;
         pend_hi_p1 <= 32'd0;
         pend_lo_p1 <= 32'd0;
         pend_we_p1 <= 1'b0;
      end else if (busy) begin
         // Any start seen while busy is a protocol violation and is ignored.
         cnt <= cnt - 4'd1;
         if (cnt == 4'd1 && pend_we_p1) begin
            hi_reg <= pend_hi_p1;
            lo_reg <= pend_lo_p1;
         end
      end else if (start) begin
         case (MDOp)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
               cnt        <= ((MDOp == OP_MULT) || (MDOp == OP_MULTU)) ? MULT_LOAD : DIV_LOAD;
               pend_hi_p1 <= res_p0[63:32];
               pend_lo_p1 <= res_p0[31:0];
               pend_we_p1 <= res_we_p0;
            end
            OP_MTHI: hi_reg <= data1;
            OP_MTLO: lo_reg <= data1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

   localparam int MULT_CYCLES = 5;
   localparam int DIV_CYCLES  = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] data1;
   logic [31:0] data2;
   logic [2:0]  MDOp;
   logic        start;
   logic        md_use;
   logic        busy;
   logic        stall;
   logic [31:0] HI;
   logic [31:0] LO;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int          m_left;
   logic [31:0] m_hi, m_lo, m_phi, m_plo;
   bit          m_pwe;

   mult_div_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
      .clk(clk), .reset(reset), .data1(data1), .data2(data2), .MDOp(MDOp),
      .start(start), .md_use(md_use), .busy(busy), .stall(stall), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   // Behavioural model of one clock edge, computed from the operation rules.
   task automatic model_edge();
      longint sa, sb;
      longint unsigned ua, ub, up;
      longint q, r;
      if (reset) begin
         m_left = 0; m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pwe = 0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0 && m_pwe) begin
            m_hi = m_phi;
            m_lo = m_plo;
         end
      end else if (start) begin
         sa = longint'($signed(data1));
         sb = longint'($signed(data2));
         ua = longint'(data1);
         ub = longint'(data2);
         case (MDOp)
            3'd1: begin
               q = sa * sb;
               m_phi = q[63:32]; m_plo = q[31:0]; m_pwe = 1; m_left = MULT_CYCLES;
            end
            3'd2: begin
               up = ua * ub;
               m_phi = up[63:32]; m_plo = up[31:0]; m_pwe = 1; m_left = MULT_CYCLES;
            end
            3'd3: begin
               m_left = DIV_CYCLES;
               m_pwe = (data2 != 0);
               if (m_pwe) begin
                  q = sa / sb; r = sa % sb;
                  m_plo = q[31:0]; m_phi = r[31:0];
               end
            end
            3'd4: begin
               m_left = DIV_CYCLES;
               m_pwe = (data2 != 0);
               if (m_pwe) begin
                  up = ua / ub; m_plo = up[31:0];
                  up = ua % ub; m_phi = up[31:0];
               end
            end
            3'd5: m_hi = data1;
            3'd6: m_lo = data1;
            default: ;
         endcase
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      start = 0; MDOp = 0; md_use = 0; reset = 0;
   endtask

   task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      MDOp = op; data1 = a; data2 = b; start = 1;
      cycle();
      start = 0; MDOp = 0;
   endtask

   task automatic test_reset();
      data1 = 0; data2 = 0; idle_inputs();
      reset = 1;
      cycle(); cycle();
      reset = 0;
      #1;
      checks++;
      if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0 || stall !== 1'b0) begin
         errors++;
         $display("FAIL reset: busy=%0b stall=%0b HI=%h LO=%h, required all zero", busy, stall, HI, LO);
      end
   endtask

   task automatic test_mult();
      MDOp = 3'd1; data1 = 32'hFFFFFFFF; data2 = 32'd2; start = 1; md_use = 1;
      #1;
      checks++;
      if (stall !== 1'b1) begin
         errors++; $display("FAIL mult_launch_stall: got %0b required 1", stall);
      end
      cycle();
      start = 0; MDOp = 0;
      data1 = 32'h5555AAAA; data2 = 32'h0;
      for (int i = 0; i < MULT_CYCLES; i++) begin
         #1;
         checks++;
         if (busy !== 1'b1 || stall !== 1'b1) begin
            errors++; $display("FAIL mult_busy[%0d]: busy=%0b stall=%0b required 1/1", i, busy, stall);
         end
         cycle();
      end
      md_use = 0;
      #1;
      checks++;
      if (busy !== 1'b0 || HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFE) begin
         errors++; $display("FAIL mult_result: busy=%0b HI=%h LO=%h required 0 ffffffff fffffffe", busy, HI, LO);
      end
   endtask

   task automatic test_multu_div_divu();
      logic [31:0] exp_hi [3];
      logic [31:0] exp_lo [3];
      logic [2:0]  ops [3];
      logic [31:0] as [3];
      logic [31:0] bs [3];
      int n;
      ops[0] = 3'd2; as[0] = 32'hFFFFFFFF; bs[0] = 32'd2; exp_hi[0] = 32'h1;        exp_lo[0] = 32'hFFFFFFFE;
      ops[1] = 3'd3; as[1] = 32'hFFFFFFF9; bs[1] = 32'd2; exp_hi[1] = 32'hFFFFFFFF; exp_lo[1] = 32'hFFFFFFFD;
      ops[2] = 3'd4; as[2] = 32'd7;        bs[2] = 32'd2; exp_hi[2] = 32'h1;        exp_lo[2] = 32'h3;
      for (int k = 0; k < 3; k++) begin
         launch(ops[k], as[k], bs[k]);
         n = 0;
         while (busy === 1'b1 && n < 20) begin
            n++;
            cycle();
         end
         checks++;
         if (n !== ((ops[k] == 3'd2) ? MULT_CYCLES : DIV_CYCLES)) begin
            errors++; $display("FAIL busy_len op%0d: got %0d cycles required %0d", ops[k], n,
                               (ops[k] == 3'd2) ? MULT_CYCLES : DIV_CYCLES);
         end
         checks++;
         if (HI !== exp_hi[k] || LO !== exp_lo[k]) begin
            errors++; $display("FAIL result op%0d: HI=%h LO=%h required %h %h", ops[k], HI, LO, exp_hi[k], exp_lo[k]);
         end
      end
   endtask

   task automatic test_mthi_mtlo_divzero();
      MDOp = 3'd5; data1 = 32'h12345678; start = 1;
      cycle();
      checks++;
      if (HI !== 32'h12345678 || busy !== 1'b0) begin
         errors++; $display("FAIL mthi: HI=%h busy=%0b required 12345678 0", HI, busy);
      end
      MDOp = 3'd6; data1 = 32'h9ABCDEF0;
      cycle();
      start = 0; MDOp = 0;
      checks++;
      if (LO !== 32'h9ABCDEF0 || HI !== 32'h12345678 || busy !== 1'b0) begin
         errors++; $display("FAIL mtlo: HI=%h LO=%h busy=%0b required 12345678 9abcdef0 0", HI, LO, busy);
      end
      launch(3'd3, 32'd100, 32'd0);
      for (int i = 0; i < DIV_CYCLES; i++) begin
         checks++;
         if (busy !== 1'b1) begin
            errors++; $display("FAIL divzero_busy[%0d]: got %0b required 1", i, busy);
         end
         cycle();
      end
      checks++;
      if (busy !== 1'b0 || HI !== 32'h12345678 || LO !== 32'h9ABCDEF0) begin
         errors++; $display("FAIL divzero_result: busy=%0b HI=%h LO=%h required 0 12345678 9abcdef0", busy, HI, LO);
      end
   endtask

   task automatic test_start_while_busy();
      int n;
      launch(3'd1, 32'd3, 32'd4);
      MDOp = 3'd1; data1 = 32'd5; data2 = 32'd6; start = 1; md_use = 1;
      n = 0;
      while (busy === 1'b1 && n < 20) begin
         n++;
         if (n == 3) MDOp = 3'd5;
         cycle();
      end
      start = 0; MDOp = 0; md_use = 0;
      checks++;
      if (n !== MULT_CYCLES) begin
         errors++; $display("FAIL busy_ignore_len: got %0d required %0d", n, MULT_CYCLES);
      end
      checks++;
      if (HI !== 32'd0 || LO !== 32'd12) begin
         errors++; $display("FAIL busy_ignore_result: HI=%h LO=%h required 0 0000000c", HI, LO);
      end
   endtask

   task automatic test_reset_abort();
      launch(3'd3, 32'd100, 32'd7);
      cycle(); cycle(); cycle();
      reset = 1;
      cycle();
      reset = 0;
      checks++;
      if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
         errors++; $display("FAIL reset_abort: busy=%0b HI=%h LO=%h required 0 0 0", busy, HI, LO);
      end
      for (int i = 0; i < DIV_CYCLES; i++) cycle();
      checks++;
      if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
         errors++; $display("FAIL reset_no_late_write: busy=%0b HI=%h LO=%h required 0 0 0", busy, HI, LO);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         reset  = ($urandom_range(0, 99) == 0);
         start  = ($urandom_range(0, 2) == 0);
         MDOp   = 3'($urandom_range(0, 7));
         md_use = $urandom_range(0, 1) == 1;
         data1  = $urandom;
         data2  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if (data1 == 32'h80000000) data1 = 32'h80000001;
         #1;
         checks++;
         if (busy !== (m_left > 0) || HI !== m_hi || LO !== m_lo ||
             stall !== (md_use && (m_left > 0 || (start && MDOp >= 3'd1 && MDOp <= 3'd4)))) begin
            errors++;
            $display("FAIL random[%0d]: busy=%0b stall=%0b HI=%h LO=%h required busy=%0b HI=%h LO=%h",
                     i, busy, stall, HI, LO, m_left > 0, m_hi, m_lo);
         end
         cycle();
      end
      idle_inputs();
   endtask

   initial begin
      m_left = 0; m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pwe = 0;
      test_reset();
      test_mult();
      test_multu_div_divu();
      test_mthi_mtlo_divzero();
      test_start_while_busy();
      test_reset_abort();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
